// File: rtl/easyaxi_seq_pkg.sv
// ----------------------------------------------------------------------------
// easyaxi_seq_pkg
// Shared definitions for the EASYAXI transaction sequencer:
//   - mode_e   : read/write pattern selected at start
//   - state_e  : sequencer FSM states
//   - default gap / timeout constants
//   - first_op_is_wr : which direction a sequence begins with
// ----------------------------------------------------------------------------
package easyaxi_seq_pkg;

   typedef enum logic [1:0] {
      MODE_RD  = 2'd0,
      MODE_WR  = 2'd1,
      MODE_ALT = 2'd2,
      MODE_WTR = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_GAP    = 3'd2,
      ST_FINISH = 3'd3,
      ST_TOUT   = 3'd4
   } state_e;

   localparam int GAP_CYC_DEF  = 3;
   localparam int TOUT_CYC_DEF = 10000;
   localparam int TOUT_W_DEF   = 14;

   // Only the read-only mode starts with a read; every other mode writes first
   // so the following reads have data to return.
   function automatic logic first_op_is_wr(input mode_e m);
      return (m != MODE_RD);
   endfunction

endpackage

// File: rtl/easyaxi_seq_wdog.sv
// ----------------------------------------------------------------------------
// easyaxi_seq_wdog
// Loadable up/down counter shared between the inter-transaction gap and the
// per-request timeout watchdog.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr        : force count to zero (highest priority)
//   load       : load load_val (below clr)
//   load_val   : value loaded by load
//   cnt_en     : advance the count by one this cycle
//   up         : 1 = count up towards limit, 0 = count down towards zero
//   limit      : terminal value when counting up
//   expired    : count sits at its terminal value for the current direction
// ----------------------------------------------------------------------------
module easyaxi_seq_wdog
   import easyaxi_seq_pkg::*;
#(
   parameter int W = TOUT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         cnt_en,
   input  logic         up,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear beats load beats counting, so a caller can restart the
   // watchdog on the same cycle it would otherwise have advanced it.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_val;
      end else if (cnt_en) begin
         count_d = up ? (count_q + W'(1)) : (count_q - W'(1));
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Terminal value depends on direction: the limit when watching a request,
   // zero when draining a gap.
   assign expired = up ? (count_q == limit) : (count_q == '0);

endmodule

// File: rtl/easyaxi_txn_seq.sv
// ----------------------------------------------------------------------------
// easyaxi_txn_seq
// Drives the rd_en/wr_en request pair of EASYAXI_TOP through a sequence of
// transactions, with an idle gap between them and a per-request timeout.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle launch pulse, honoured only when idle
//   mode              : 0 read-only, 1 write-only, 2 alternating W/R,
//                       3 all writes then all reads
//   txn_num           : transactions per direction pass
//   rd_en / rd_done   : read request level and its completion
//   wr_en / wr_done   : write request level and its completion
//   busy              : sequence in progress
//   done              : one-cycle pulse on clean completion
//   timeout           : sticky error, cleared by reset or the next start
//   rd_cnt / wr_cnt   : completed reads / writes in this sequence
// ----------------------------------------------------------------------------
module easyaxi_txn_seq
   import easyaxi_seq_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int GAP_CYC  = GAP_CYC_DEF,
   parameter int TOUT_CYC = TOUT_CYC_DEF,
   parameter int TOUT_W   = TOUT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] txn_num,
   output logic             rd_en,
   input  logic             rd_done,
   output logic             wr_en,
   input  logic             wr_done,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt
);

   localparam logic [TOUT_W-1:0] TOUT_LIM = TOUT_W'(TOUT_CYC);
   localparam logic [TOUT_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? TOUT_W'(GAP_CYC - 1) : '0;

   state_e           state_q,   state_d;
   mode_e            mode_q,    mode_d;
   logic [CNT_W-1:0] txn_q,     txn_d;
   logic             cur_wr_q,  cur_wr_d;
   logic             rd_en_q,   rd_en_d;
   logic             wr_en_q,   wr_en_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] rd_cnt_q,  rd_cnt_d;
   logic [CNT_W-1:0] wr_cnt_q,  wr_cnt_d;

   logic             wd_clr;
   logic             wd_load;
   logic             wd_cnt;
   logic             wd_up;
   logic             wd_expired;

   logic             match_done;
   logic [CNT_W-1:0] rd_nx;
   logic [CNT_W-1:0] wr_nx;
   logic             seq_end;
   logic             nx_wr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : (v + CNT_W'(1));
   endfunction

   // One counter serves both jobs because REQ and GAP never overlap: it
   // counts up against the timeout in REQ and drains the gap in GAP.
   assign wd_up = (state_q != ST_GAP);

   easyaxi_seq_wdog #(
      .W (TOUT_W)
   ) u_wdog (
      .clk      (clk),
      .rst      (rst),
      .clr      (wd_clr),
      .load     (wd_load),
      .load_val (GAP_LOAD),
      .cnt_en   (wd_cnt),
      .up       (wd_up),
      .limit    (TOUT_LIM),
      .expired  (wd_expired)
   );

   // Bookkeeping for the op currently in flight: which done counts, what the
   // counters become if it completes, whether that ends the sequence and
   // which direction comes next.
   always_comb begin
      match_done = cur_wr_q ? wr_done : rd_done;
      rd_nx      = cur_wr_q ? rd_cnt_q : sat_inc(rd_cnt_q);
      wr_nx      = cur_wr_q ? sat_inc(wr_cnt_q) : wr_cnt_q;
      seq_end    = 1'b0;
      nx_wr      = cur_wr_q;
      case (mode_q)
         MODE_RD: begin
            seq_end = (rd_nx == txn_q);
            nx_wr   = 1'b0;
         end
         MODE_WR: begin
            seq_end = (wr_nx == txn_q);
            nx_wr   = 1'b1;
         end
         MODE_ALT: begin
            seq_end = (rd_nx == txn_q) && (wr_nx == txn_q);
            nx_wr   = ~cur_wr_q;
         end
         MODE_WTR: begin
            seq_end = (rd_nx == txn_q) && (wr_nx == txn_q);
            nx_wr   = (wr_nx != txn_q);
         end
         default: begin
            seq_end = 1'b1;
            nx_wr   = 1'b0;
         end
      endcase
   end

   // Sequencer next-state and registered outputs. Enables are computed here
   // and registered, so they appear the cycle after REQ is entered and fall
   // the cycle after the matching done (or the timeout) is seen.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      txn_d     = txn_q;
      cur_wr_d  = cur_wr_q;
      rd_en_d   = 1'b0;
      wr_en_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      timeout_d = timeout_q;
      rd_cnt_d  = rd_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      wd_clr    = 1'b0;
      wd_load   = 1'b0;
      wd_cnt    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d    = mode_e'(mode);
               txn_d     = txn_num;
               cur_wr_d  = first_op_is_wr(mode_e'(mode));
               rd_cnt_d  = '0;
               wr_cnt_d  = '0;
               timeout_d = 1'b0;
               busy_d    = 1'b1;
               wd_clr    = 1'b1;
               state_d   = (txn_num == '0) ? ST_FINISH : ST_REQ;
            end
         end
         ST_REQ: begin
            if (match_done) begin
               rd_cnt_d = rd_nx;
               wr_cnt_d = wr_nx;
               cur_wr_d = nx_wr;
               if (seq_end) begin
                  state_d = ST_FINISH;
               end else if (GAP_CYC == 0) begin
                  state_d = ST_REQ;
                  wd_clr  = 1'b1;
               end else begin
                  state_d = ST_GAP;
                  wd_load = 1'b1;
               end
            end else if (wd_expired) begin
               state_d = ST_TOUT;
            end else begin
               rd_en_d = ~cur_wr_q;
               wr_en_d = cur_wr_q;
               wd_cnt  = 1'b1;
            end
         end
         ST_GAP: begin
            if (wd_expired) begin
               state_d = ST_REQ;
               wd_clr  = 1'b1;
            end else begin
               wd_cnt = 1'b1;
            end
         end
         ST_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_TOUT: begin
            timeout_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset wins over everything, including a
   // start arriving on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mode_q    <= MODE_RD;
         txn_q     <= '0;
         cur_wr_q  <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         txn_q     <= txn_d;
         cur_wr_q  <= cur_wr_d;
         rd_en_q   <= rd_en_d;
         wr_en_q   <= wr_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
      end
   end

   assign rd_en   = rd_en_q;
   assign wr_en   = wr_en_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign timeout = timeout_q;
   assign rd_cnt  = rd_cnt_q;
   assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_easyaxi_txn_seq.sv
// ----------------------------------------------------------------------------
// tb_easyaxi_txn_seq
// Self-checking bench for easyaxi_txn_seq: a responder stands in for
// EASYAXI_TOP, a transaction-queue model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed cycle numbers.
// ----------------------------------------------------------------------------
module tb_easyaxi_txn_seq;
   import easyaxi_seq_pkg::*;

   localparam int CNT_W = 16;
   localparam int GAP   = 3;
   localparam int TOUT  = 50;
   localparam int TW    = 8;
   localparam int RESP  = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [CNT_W-1:0] txn_num;
   logic             rd_en;
   logic             rd_done;
   logic             wr_en;
   logic             wr_done;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] wr_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int start_cyc;

   bit resp_rd_on = 1'b1;
   bit resp_wr_on = 1'b1;
   bit stray_on   = 1'b0;

   int rise_cyc[$];
   int rise_op[$];
   int fall_cyc[$];
   int done_cyc[$];

   bit m_active, m_rd_en, m_wr_en, m_busy, m_done, m_tout;
   int m_rd_cnt, m_wr_cnt;
   int m_ops[$];
   int rise_at  = -1;
   int fin_at   = -1;
   int tout_at  = -1;
   int m_rise_c = -1;

   always #5 clk = ~clk;

   easyaxi_txn_seq #(
      .CNT_W    (CNT_W),
      .GAP_CYC  (GAP),
      .TOUT_CYC (TOUT),
      .TOUT_W   (TW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mode    (mode),
      .txn_num (txn_num),
      .rd_en   (rd_en),
      .rd_done (rd_done),
      .wr_en   (wr_en),
      .wr_done (wr_done),
      .busy    (busy),
      .done    (done),
      .timeout (timeout),
      .rd_cnt  (rd_cnt),
      .wr_cnt  (wr_cnt)
   );

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -99999;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] m, input int n);
      @(negedge clk);
      start     = 1'b1;
      mode      = m;
      txn_num   = CNT_W'(n);
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s: busy still %b after %0d cycles, required 0", name, busy, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic clearLogs();
      rise_cyc.delete();
      rise_op.delete();
      fall_cyc.delete();
      done_cyc.delete();
   endtask

   // Responder standing in for EASYAXI_TOP: returns a done RESP cycles after
   // an enable rises, optionally never, optionally with a stray read done
   // while a write is outstanding.
   initial begin
      int rd_age, wr_age;
      rd_age  = 0;
      wr_age  = 0;
      rd_done = 1'b0;
      wr_done = 1'b0;
      forever begin
         @(negedge clk);
         rd_age  = (rd_en === 1'b1) ? rd_age + 1 : 0;
         wr_age  = (wr_en === 1'b1) ? wr_age + 1 : 0;
         rd_done = (resp_rd_on && rd_age == RESP + 1) || (stray_on && wr_age == 2);
         wr_done = resp_wr_on && (wr_age == RESP + 1);
      end
   end

   // Model and compare: after every edge the model advances from the
   // sampled inputs using the sequencer's timing rules over a queue of
   // pending ops, then the DUT outputs are checked against it.
   initial begin
      bit s_start, s_rst, s_rd, s_wr, o_rd, o_wr, o_act, mat, p_rd, p_wr;
      int s_mode, s_txn, n;
      logic [36:0] exp_v, act_v;
      p_rd = 1'b0;
      p_wr = 1'b0;
      forever begin
         @(posedge clk);
         s_start = (start === 1'b1);
         s_rst   = (rst === 1'b1);
         s_rd    = (rd_done === 1'b1);
         s_wr    = (wr_done === 1'b1);
         s_mode  = int'(mode);
         s_txn   = int'(txn_num);
         cyc++;
         n      = cyc;
         o_rd   = m_rd_en;
         o_wr   = m_wr_en;
         o_act  = m_active;
         m_done = 1'b0;
         if (s_rst) begin
            m_active = 0; m_rd_en = 0; m_wr_en = 0; m_busy = 0; m_tout = 0;
            m_rd_cnt = 0; m_wr_cnt = 0;
            m_ops.delete();
            rise_at = -1; fin_at = -1; tout_at = -1;
         end else begin
            if (m_active && n == fin_at) begin
               m_done = 1; m_busy = 0; m_active = 0; fin_at = -1;
            end
            if (m_active && n == tout_at) begin
               m_tout = 1; m_busy = 0; m_active = 0; tout_at = -1;
            end
            if (m_active && n == rise_at) begin
               if (m_ops[0] == 1) m_wr_en = 1; else m_rd_en = 1;
               m_rise_c = n;
               rise_at  = -1;
            end
            if (o_rd || o_wr) begin
               mat = o_wr ? s_wr : s_rd;
               if (mat) begin
                  m_rd_en = 0; m_wr_en = 0;
                  if (o_wr) m_wr_cnt++; else m_rd_cnt++;
                  void'(m_ops.pop_front());
                  if (m_ops.size() == 0) fin_at = n + 1;
                  else rise_at = n + GAP + 1;
               end else if (n == m_rise_c + TOUT) begin
                  m_rd_en = 0; m_wr_en = 0;
                  tout_at = n + 1;
               end
            end
            if (!o_act && s_start) begin
               m_ops.delete();
               for (int i = 0; i < s_txn; i++) begin
                  if (s_mode == 0) m_ops.push_back(0);
                  else if (s_mode == 1) m_ops.push_back(1);
                  else if (s_mode == 2) begin m_ops.push_back(1); m_ops.push_back(0); end
                  else m_ops.push_back(1);
               end
               if (s_mode == 3)
                  for (int i = 0; i < s_txn; i++) m_ops.push_back(0);
               m_active = 1; m_busy = 1; m_tout = 0;
               m_rd_cnt = 0; m_wr_cnt = 0;
               if (m_ops.size() == 0) fin_at = n + 1;
               else rise_at = n + 1;
            end
         end
         #1;
         exp_v = {m_rd_en, m_wr_en, m_busy, m_done, m_tout, CNT_W'(m_rd_cnt), CNT_W'(m_wr_cnt)};
         act_v = {rd_en, wr_en, busy, done, timeout, rd_cnt, wr_cnt};
         checks++;
         if (act_v !== exp_v) begin
            failures++;
            $display("[TB] FAIL cycle_outputs cyc=%0d rd_en,wr_en,busy,done,timeout,rd_cnt,wr_cnt got %b %b %b %b %b %0d %0d required %b %b %b %b %b %0d %0d",
                     cyc, rd_en, wr_en, busy, done, timeout, rd_cnt, wr_cnt,
                     m_rd_en, m_wr_en, m_busy, m_done, m_tout, m_rd_cnt, m_wr_cnt);
         end
         checks++;
         if (rd_en === 1'b1 && wr_en === 1'b1) begin
            failures++;
            $display("[TB] FAIL en_exclusive cyc=%0d got rd_en&wr_en=1 required 0", cyc);
         end
         if (rd_en === 1'b1 && !p_rd) begin rise_cyc.push_back(cyc); rise_op.push_back(0); end
         if (wr_en === 1'b1 && !p_wr) begin rise_cyc.push_back(cyc); rise_op.push_back(1); end
         if ((rd_en !== 1'b1 && p_rd) || (wr_en !== 1'b1 && p_wr)) fall_cyc.push_back(cyc);
         if (done === 1'b1) done_cyc.push_back(cyc);
         p_rd = (rd_en === 1'b1);
         p_wr = (wr_en === 1'b1);
      end
   end

   // Hard stop in case a scenario hangs.
   initial begin
      #1000000;
      failures++;
      $display("[TB] FAIL global_timeout: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] stopped by time limit");
   end

   // Directed scenarios.
   initial begin
      int s0;
      rst     = 1'b1;
      start   = 1'b0;
      mode    = 2'd0;
      txn_num = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_rd_en", int'(rd_en), 0);
      checkOutput("reset_timeout", int'(timeout), 0);
      rst = 1'b0;

      $display("[TB] mode 0, 3 reads");
      clearLogs();
      applyStimulus(2'd0, 3);
      waitIdle("a_idle", 400);
      checkOutput("a_rd_cnt", int'(rd_cnt), 3);
      checkOutput("a_wr_cnt", int'(wr_cnt), 0);
      checkOutput("a_timeout", int'(timeout), 0);
      checkOutput("a_rises", rise_cyc.size(), 3);
      checkOutput("a_first_lat", qat(rise_cyc, 0) - start_cyc, 2);
      checkOutput("a_spacing1", qat(rise_cyc, 1) - qat(rise_cyc, 0), 10);
      checkOutput("a_spacing2", qat(rise_cyc, 2) - qat(rise_cyc, 1), 10);
      checkOutput("a_done_lat", qat(done_cyc, 0) - start_cyc, 29);
      checkOutput("a_done_cnt", done_cyc.size(), 1);

      $display("[TB] mode 2, alternating");
      clearLogs();
      applyStimulus(2'd2, 2);
      waitIdle("b_idle", 400);
      checkOutput("b_rd_cnt", int'(rd_cnt), 2);
      checkOutput("b_wr_cnt", int'(wr_cnt), 2);
      checkOutput("b_op0", qat(rise_op, 0), 1);
      checkOutput("b_op1", qat(rise_op, 1), 0);
      checkOutput("b_op2", qat(rise_op, 2), 1);
      checkOutput("b_op3", qat(rise_op, 3), 0);

      $display("[TB] mode 3 with stray read done");
      clearLogs();
      stray_on = 1'b1;
      applyStimulus(2'd3, 2);
      waitIdle("c_idle", 400);
      stray_on = 1'b0;
      checkOutput("c_rd_cnt", int'(rd_cnt), 2);
      checkOutput("c_wr_cnt", int'(wr_cnt), 2);
      checkOutput("c_op0", qat(rise_op, 0), 1);
      checkOutput("c_op1", qat(rise_op, 1), 1);
      checkOutput("c_op2", qat(rise_op, 2), 0);
      checkOutput("c_op3", qat(rise_op, 3), 0);

      $display("[TB] mode 1 with no write response");
      clearLogs();
      resp_wr_on = 1'b0;
      applyStimulus(2'd1, 4);
      waitIdle("d_idle", 400);
      resp_wr_on = 1'b1;
      checkOutput("d_en_width", qat(fall_cyc, 0) - qat(rise_cyc, 0), TOUT);
      checkOutput("d_timeout", int'(timeout), 1);
      checkOutput("d_wr_cnt", int'(wr_cnt), 0);
      checkOutput("d_busy", int'(busy), 0);
      checkOutput("d_no_done", done_cyc.size(), 0);

      $display("[TB] zero-length sequence, then ignored start");
      clearLogs();
      applyStimulus(2'd0, 0);
      waitIdle("e_idle", 50);
      checkOutput("e_done_lat", qat(done_cyc, 0) - start_cyc, 2);
      checkOutput("e_no_en", rise_cyc.size(), 0);
      checkOutput("e_timeout_clr", int'(timeout), 0);
      clearLogs();
      applyStimulus(2'd0, 2);
      s0 = start_cyc;
      repeat (3) @(negedge clk);
      applyStimulus(2'd1, 5);
      waitIdle("e2_idle", 400);
      checkOutput("e2_rd_cnt", int'(rd_cnt), 2);
      checkOutput("e2_wr_cnt", int'(wr_cnt), 0);
      checkOutput("e2_rises", rise_cyc.size(), 2);
      checkOutput("e2_done_lat", qat(done_cyc, 0) - s0, 19);

      $display("[TB] reset mid-sequence");
      clearLogs();
      applyStimulus(2'd0, 3);
      for (int k = 0; k < 100 && rise_cyc.size() < 2; k++) @(negedge clk);
      checkOutput("f_second_rise", rise_cyc.size(), 2);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("f_rd_en", int'(rd_en), 0);
      checkOutput("f_busy", int'(busy), 0);
      checkOutput("f_rd_cnt", int'(rd_cnt), 0);
      repeat (10) @(negedge clk);
      checkOutput("f_no_done", done_cyc.size(), 0);
      clearLogs();
      applyStimulus(2'd0, 1);
      waitIdle("f_idle", 200);
      checkOutput("f2_rd_cnt", int'(rd_cnt), 1);
      checkOutput("f2_done", done_cyc.size(), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/easyaxi_txn_seq.md
Name: easyaxi_txn_seq

Overview:
- Synthesizable transaction sequencer that drives the rd_en/wr_en request pair of EASYAXI_TOP and consumes its rd_done/wr_done responses.
- Replaces the fixed single-read stimulus in the top-level bench with a parametrised sequence of N transactions in one of four read/write modes.
- Adds an inter-transaction gap, a per-transaction timeout watchdog and pass/fail status.
- Sits between the bench (or a future on-chip self-test) and EASYAXI_TOP.

Parameters:
- CNT_W, 16: width of the transaction count and the rd/wr counters.
- GAP_CYC, 3: idle cycles between one done and the next request; legal range is 0 or more.
- TOUT_CYC, 10000: maximum cycles a request may wait for its done before the timeout fires; must be at least 1.
- TOUT_W, 14: width of the watchdog counter; must satisfy 2^TOUT_W > TOUT_CYC.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; launches a sequence; sampled only in IDLE.
- mode  in  2  0=read-only, 1=write-only, 2=alternating (write first), 3=all writes then all reads; latched at start.
- txn_num  in  CNT_W  transactions per direction-pass; latched at start.
- rd_en  out  1  read request level to EASYAXI_TOP.
- rd_done  in  1  read completion from EASYAXI_TOP.
- wr_en  out  1  write request level to EASYAXI_TOP.
- wr_done  in  1  write completion from EASYAXI_TOP.
- busy  out  1  high from the cycle after start until FINISH/TOUT.
- done  out  1  one-cycle pulse when the sequence completes without timeout.
- timeout  out  1  sticky error flag; cleared by rst or by the next accepted start.
- rd_cnt  out  CNT_W  completed reads in the current sequence.
- wr_cnt  out  CNT_W  completed writes in the current sequence.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state goes to IDLE; all outputs are 0 on the following cycle. This also holds mid-sequence: any asserted rd_en/wr_en drops and no done pulse is produced.
- FSM states: IDLE, REQ, GAP, FINISH, TOUT.
- IDLE:
  - On start=1, latch mode and txn_num, clear rd_cnt, wr_cnt and timeout.
  - If txn_num=0, go to FINISH. Otherwise go to REQ with the first op selected.
  - First op is read for mode 0; write for modes 1, 2 and 3.
- REQ:
  - Assert the enable of the current op (rd_en or wr_en, never both) as a registered level, starting the cycle after entry.
  - The watchdog increments every cycle in REQ.
  - When the matching done is sampled high:
    - Deassert the enable the next cycle.
    - Increment the matching counter.
    - Reset the watchdog.
    - Select the next op.
    - If the sequence is exhausted, go to FINISH; else go to GAP, or directly to REQ when GAP_CYC=0.
  - Completion rules by mode:
    - Modes 0 and 1: txn_num transactions.
    - Mode 2: txn_num writes and txn_num reads, interleaved W,R,W,R…
    - Mode 3: txn_num writes, then txn_num reads.
  - A done for the non-current direction is ignored: no count, no state change. Simultaneous rd_done and wr_done count only the current op.
  - If the watchdog reaches TOUT_CYC before the matching done, go to TOUT and drop the enable.
- GAP: both enables low; count GAP_CYC cycles, then go to REQ. A stray done in GAP is ignored.
- FINISH: pulse done for 1 cycle, drop busy, return to IDLE the next cycle.
- TOUT: set timeout, drop busy, no done pulse, return to IDLE. rd_cnt and wr_cnt hold their values for diagnosis.
- start outside IDLE is ignored. start asserted together with rst is ignored.
- Counters saturate at all-ones and never wrap.
- Latency: start to first enable is 2 cycles. Done to the next enable is GAP_CYC+2 cycles.

Decomposition:
- Shared package easyaxi_seq_pkg holds:
  - mode encodings MODE_RD, MODE_WR, MODE_ALT, MODE_WTR;
  - the FSM state typedef;
  - the default GAP and TOUT constants.
- One natural sub-module, easyaxi_seq_wdog: a loadable down/up counter with clear and expiry flag, reused for both the GAP count and the timeout.

Test Plan:
- Mode 0, txn_num=3, model returns rd_done 5 cycles after rd_en → 3 rd_en pulses, rd_cnt=3, wr_cnt=0, done pulse, each gap 3 cycles, timeout=0.
- Mode 2, txn_num=2 → enable order W,R,W,R; wr_cnt=2, rd_cnt=2; rd_en and wr_en never high together.
- Mode 3, txn_num=2, model asserts rd_done while wr_en is active → the stray done is ignored, order W,W,R,R, final counts 2/2.
- Mode 1, txn_num=4, model never returns wr_done, TOUT_CYC=50 → wr_en drops 50 cycles after it rose; timeout=1, wr_cnt=0, no done, busy=0.
- txn_num=0 with start → done pulses 2 cycles later, no enables; a second start while busy in a mode-0 run is ignored.
- rst=1 during the second read of a mode-0 run → rd_en, busy and counters are 0 the next cycle; a new start works normally.
